// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into WIDTH-cycle level pulses followed by a GAP-cycle hold-off.
// Optional feature macro: PULSE_STRETCHER_RETRIGGER_EN (a trigger while the pulse is high restarts it).
module pulse_stretcher #(
   parameter int WIDTH = 8,
   parameter int GAP   = 2,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out,
   output logic busy,
   output logic drop
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_HOLD   = 2'd2;

   // Counters hold "cycles remaining minus one", so a zero count means last cycle of the phase.
   localparam logic [CNT_W-1:0] WIDTH_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;
   logic             drop_q, drop_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drop_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in) begin
               state_d = S_ACTIVE;
               cnt_d   = WIDTH_LOAD;
            end
         end
         S_ACTIVE: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
            if (in) begin
               cnt_d = WIDTH_LOAD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (GAP > 0) begin
               state_d = S_HOLD;
               cnt_d   = GAP_LOAD;
            end else begin
               state_d = S_IDLE;
            end
`else
            drop_d = in;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (GAP > 0) begin
               state_d = S_HOLD;
               cnt_d   = GAP_LOAD;
            end else begin
               state_d = S_IDLE;
            end
`endif
         end
         S_HOLD: begin
            drop_d = in;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Outputs are registered copies of the next-state decode, so they change with the state.
      out_d  = (state_d == S_ACTIVE);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign drop = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: two instances (WIDTH=4/GAP=2 and WIDTH=1/GAP=0) checked every cycle
// against a timeline model, plus directed literal checks.
module tb_pulse_stretcher;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       trig = 1'b0;
   logic [1:0] out_v, busy_v, drop_v;

   always #5 clk = ~clk;

   pulse_stretcher #(.WIDTH(4), .GAP(2), .CNT_W(8)) u0 (
      .clk(clk), .reset(reset), .in(trig),
      .out(out_v[0]), .busy(busy_v[0]), .drop(drop_v[0])
   );

   pulse_stretcher #(.WIDTH(1), .GAP(0), .CNT_W(8)) u1 (
      .clk(clk), .reset(reset), .in(trig),
      .out(out_v[1]), .busy(busy_v[1]), .drop(drop_v[1])
   );

`ifdef PULSE_STRETCHER_RETRIGGER_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   localparam int WA[2] = '{4, 1};
   localparam int GA[2] = '{2, 0};

   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;
   bit   chk_en   = 1'b0;
   // Model: last edge after which out / busy are still high, per instance.
   int   out_last[2]  = '{-100, -100};
   int   busy_last[2] = '{-100, -100};
   logic exp_out[2]   = '{1'b0, 1'b0};
   logic exp_busy[2]  = '{1'b0, 1'b0};
   logic exp_drop[2]  = '{1'b0, 1'b0};

   task automatic model(input logic r, input logic i);
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            out_last[k]  = edge_n - 1;
            busy_last[k] = edge_n - 1;
            exp_drop[k]  = 1'b0;
         end else begin
            bit idle, active, accept;
            idle   = (edge_n - 1) > busy_last[k];
            active = (edge_n - 1) <= out_last[k];
            accept = i && (idle || (active && RETRIG));
            if (accept) begin
               out_last[k]  = edge_n + WA[k] - 1;
               busy_last[k] = edge_n + WA[k] + GA[k] - 1;
            end
            exp_drop[k] = i && !accept;
         end
         exp_out[k]  = (edge_n <= out_last[k]);
         exp_busy[k] = (edge_n <= busy_last[k]);
      end
   endtask

   task automatic cmp(input string nm, input int k, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d edge %0d: got %b expected %b", nm, k, edge_n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            cmp("model_out", k, out_v[k], exp_out[k]);
            cmp("model_busy", k, busy_v[k], exp_busy[k]);
            cmp("model_drop", k, drop_v[k], exp_drop[k]);
         end
      end
   end

   task automatic step(input logic r, input logic i);
      reset = r;
      trig  = i;
      @(posedge clk);
      edge_n++;
      model(r, i);
      #1;
   endtask

   // Directed sequence: bit j of each pattern is the input / expected output after offset j.
   task automatic seq(input string nm, input int k, input int len,
                      input logic [15:0] ip, input logic [15:0] op,
                      input logic [15:0] bp, input logic [15:0] dp);
      logic a;
      for (int j = 0; j < len; j++) begin
         step(1'b0, ip[j]);
         a = out_v[k];  cmp({nm, "_out"}, k, a, op[j]);
         a = busy_v[k]; cmp({nm, "_busy"}, k, a, bp[j]);
         a = drop_v[k]; cmp({nm, "_drop"}, k, a, dp[j]);
      end
      $display("seq %s dut%0d done at edge %0d", nm, k, edge_n);
   endtask

   task automatic idle_steps(input int n);
      for (int j = 0; j < n; j++) step(1'b0, 1'b0);
   endtask

   initial begin
      logic a;
      // Reset held with a trigger present: nothing may come out.
      for (int j = 0; j < 3; j++) begin
         step(1'b1, 1'b1);
         chk_en = 1'b1;
         a = out_v[0];  cmp("rst_out", 0, a, 1'b0);
         a = busy_v[0]; cmp("rst_busy", 0, a, 1'b0);
         a = drop_v[0]; cmp("rst_drop", 0, a, 1'b0);
      end
      for (int j = 0; j < 4; j++) begin
         step(1'b0, 1'b0);
         a = out_v[0]; cmp("post_rst_out", 0, a, 1'b0);
      end

      seq("single", 0, 9, 16'h0001, 16'h000F, 16'h003F, 16'h0000);
      idle_steps(3);
      if (RETRIG)
         seq("retrig", 0, 10, 16'h0005, 16'h003F, 16'h00FF, 16'h0000);
      else
         seq("no_retrig", 0, 10, 16'h0005, 16'h000F, 16'h003F, 16'h0004);
      idle_steps(3);
      seq("holdoff", 0, 14, 16'h00E1, 16'h078F, 16'h1FBF, 16'h0060);
      idle_steps(12);
      if (RETRIG)
         seq("held_g0", 1, 9, 16'h00FF, 16'h00FF, 16'h00FF, 16'h0000);
      else
         seq("held_g0", 1, 9, 16'h00FF, 16'h0055, 16'h0055, 16'h00AA);
      idle_steps(12);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      a = out_v[0]; cmp("mid_pulse_out", 0, a, 1'b1);
      step(1'b1, 1'b0);
      a = out_v[0];  cmp("mid_rst_out", 0, a, 1'b0);
      a = busy_v[0]; cmp("mid_rst_busy", 0, a, 1'b0);
      $display("mid-pulse reset done at edge %0d", edge_n);

      // Random traffic: sparse and bursty triggers, occasional reset.
      for (int j = 0; j < 4000; j++) begin
         logic r, i;
         r = ($urandom_range(0, 199) == 0);
         if (j % 1000 < 500) i = ($urandom_range(0, 5) == 0);
         else                i = ($urandom_range(0, 3) != 0);
         step(r, i);
      end
      $display("random phase done at edge %0d", edge_n);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
